branch_controller: RTL and testbench

BRANCH_CONTROLLER -- requirements
Module: branch_controller

---
 rtl/branch_controller_if.sv | 40 ++++
 rtl/branch_controller.sv | 125 ++++++++++++
 tb/tb_branch_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_controller_if.sv
// Execute-stage branch/flag signals and the redirect/flush/counter results
// exchanged between the execute pipeline and the branch controller.
interface branch_controller_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 BranchE;
  logic [1:0]           InstrSelE;
  logic                 FlagWriteE;
  logic [3:0]           ALUFlagsE;
  logic                 StallE;
  logic [PC_WIDTH-1:0]  BranchTargetE;
  logic                 CntClr;

  logic [3:0]           Flags;
  logic                 RedirectValid;
  logic [PC_WIDTH-1:0]  RedirectPC;
  logic                 FlushD;
  logic                 FlushE;
  logic                 CondErr;
  logic [CNT_WIDTH-1:0] BranchCnt;
  logic [CNT_WIDTH-1:0] TakenCnt;
  logic [1:0]           DbgState;

  // Redirect handshake: fetch has no ready; RedirectValid is a one-cycle
  // strobe and fetch must load RedirectPC in exactly that cycle. The execute
  // stage offers BranchE/FlagWriteE every cycle; they take effect only when
  // the controller is idle and StallE is low.
  modport slave (
    input  BranchE, InstrSelE, FlagWriteE, ALUFlagsE, StallE, BranchTargetE, CntClr,
    output Flags, RedirectValid, RedirectPC, FlushD, FlushE, CondErr,
           BranchCnt, TakenCnt, DbgState
  );

  modport master (
    output BranchE, InstrSelE, FlagWriteE, ALUFlagsE, StallE, BranchTargetE, CntClr,
    input  Flags, RedirectValid, RedirectPC, FlushD, FlushE, CondErr,
           BranchCnt, TakenCnt, DbgState
  );
endinterface

// File: rtl/branch_controller.sv
// Resolves execute-stage branches against the architectural flags, issues a
// one-cycle fetch redirect with a two-cycle pipeline flush, and counts branches.
module branch_controller #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  localparam logic [1:0] SEL_EQ  = 2'b00;
  localparam logic [1:0] SEL_RSV = 2'b01;
  localparam logic [1:0] SEL_GT  = 2'b10;
  localparam logic [1:0] SEL_AL  = 2'b11;

  logic [1:0]           state_q, state_d;
  logic [3:0]           flags_q, flags_d;
  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic                 cond_err_q, cond_err_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  logic accepted;
  logic cond_true;
  logic branch_acc;
  logic taken;

  logic flag_n, flag_z, flag_v;
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];

  assign accepted   = (state_q == ST_IDLE) && !bus.StallE;
  assign branch_acc = accepted && bus.BranchE;
  assign taken      = branch_acc && cond_true;

  // Condition is evaluated on the registered flags, so a flag write in the
  // same cycle as the branch does not influence it.
  always_comb begin
    cond_true = 1'b0;
    case (bus.InstrSelE)
      SEL_EQ:  cond_true = flag_z;
      SEL_GT:  cond_true = !flag_z && (flag_n == flag_v);
      SEL_AL:  cond_true = 1'b1;
      SEL_RSV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:     state_d = taken ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: state_d = ST_DRAIN;
      ST_DRAIN:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flags_d       = flags_q;
    redirect_pc_d = redirect_pc_q;
    cond_err_d    = cond_err_q;
    if (accepted && bus.FlagWriteE) begin
      flags_d = bus.ALUFlagsE;
    end
    if (taken) begin
      redirect_pc_d = bus.BranchTargetE;
    end
    if (branch_acc && (bus.InstrSelE == SEL_RSV)) begin
      cond_err_d = 1'b1;
    end
  end

  // Saturating counters; a clear overrides any same-cycle increment.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (bus.CntClr) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else begin
      if (branch_acc && (branch_cnt_q != '1)) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (taken && (taken_cnt_q != '1)) begin
        taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      flags_q       <= 4'b0000;
      redirect_pc_q <= '0;
      cond_err_q    <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      redirect_pc_q <= redirect_pc_d;
      cond_err_q    <= cond_err_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign bus.Flags         = flags_q;
  assign bus.RedirectValid = (state_q == ST_REDIRECT);
  assign bus.RedirectPC    = redirect_pc_q;
  assign bus.FlushD        = (state_q == ST_REDIRECT);
  assign bus.FlushE        = (state_q == ST_REDIRECT) || (state_q == ST_DRAIN);
  assign bus.CondErr       = cond_err_q;
  assign bus.BranchCnt     = branch_cnt_q;
  assign bus.TakenCnt      = taken_cnt_q;
  assign bus.DbgState      = state_q;

endmodule

// File: tb/tb_branch_controller.sv
// Bench for branch_controller: directed vector table, saturation/clear
// sequence, then random stimulus against a countdown-based reference model.
module tb_branch_controller;
  localparam int PW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic        rst;
    logic        br;
    logic [1:0]  sel;
    logic        fw;
    logic [3:0]  alu;
    logic        stall;
    logic [31:0] tgt;
    logic        clr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [3:0]  ef;
    logic        erv;
    logic [31:0] epc;
    logic        efd;
    logic        efe;
    logic        eerr;
    logic [3:0]  eb;
    logic [3:0]  et;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  branch_controller_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  branch_controller #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy counts remaining flush cycles: 2 = redirect cycle, 1 = drain cycle.
  int       m_busy;
  logic [3:0] m_flags;
  logic [PW-1:0] m_pc;
  logic     m_err;
  int       m_b, m_t;

  task automatic model_step(input stim_t s);
    bit z, n, v, cond;
    if (s.rst) begin
      m_busy = 0; m_flags = 4'b0; m_pc = '0; m_err = 1'b0; m_b = 0; m_t = 0;
      exp_q.delete();
      return;
    end
    if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end else if (!s.stall) begin
      n = m_flags[3]; z = m_flags[2]; v = m_flags[0];
      cond = (s.sel == 2'd0) ? z :
             (s.sel == 2'd2) ? (!z && (n == v)) :
             (s.sel == 2'd3);
      if (s.br) begin
        if (m_b < CNT_MAX) m_b = m_b + 1;
        if (s.sel == 2'd1) m_err = 1'b1;
        if (cond) begin
          if (m_t < CNT_MAX) m_t = m_t + 1;
          m_pc = s.tgt;
          m_busy = 2;
          exp_q.push_back(s.tgt);
        end
      end
      if (s.fw) m_flags = s.alu;
    end
    if (s.clr) begin
      m_b = 0; m_t = 0;
    end
  endtask

  task automatic check_model();
    chk("flags",     bus.Flags, m_flags);
    chk("rv",        bus.RedirectValid, m_busy == 2);
    chk("pc",        bus.RedirectPC, m_pc);
    chk("flushd",    bus.FlushD, m_busy == 2);
    chk("flushe",    bus.FlushE, m_busy != 0);
    chk("conderr",   bus.CondErr, m_err);
    chk("branchcnt", bus.BranchCnt, m_b);
    chk("takencnt",  bus.TakenCnt, m_t);
    if (bus.RedirectValid === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_pc", bus.RedirectPC, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input stim_t s);
    @(negedge clk);
    rst               = s.rst;
    bus.BranchE       = s.br;
    bus.InstrSelE     = s.sel;
    bus.FlagWriteE    = s.fw;
    bus.ALUFlagsE     = s.alu;
    bus.StallE        = s.stall;
    bus.BranchTargetE = s.tgt;
    bus.CntClr        = s.clr;
    @(posedge clk);
    model_step(s);
    #1;
    check_model();
  endtask

  function automatic stim_t st(input logic r, input logic br, input logic [1:0] sel,
                               input logic fw, input logic [3:0] alu, input logic stall,
                               input logic [31:0] tgt, input logic clr);
    stim_t s;
    s.rst = r; s.br = br; s.sel = sel; s.fw = fw; s.alu = alu;
    s.stall = stall; s.tgt = tgt; s.clr = clr;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input logic [3:0] ef, input logic erv,
                              input logic [31:0] epc, input logic efd, input logic efe,
                              input logic eerr, input logic [3:0] eb, input logic [3:0] et);
    vec_t v;
    v.s = s; v.ef = ef; v.erv = erv; v.epc = epc; v.efd = efd; v.efe = efe;
    v.eerr = eerr; v.eb = eb; v.et = et;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    stim_t idle;
    rst = 1'b1;
    bus.BranchE = 0; bus.InstrSelE = 0; bus.FlagWriteE = 0; bus.ALUFlagsE = 0;
    bus.StallE = 0; bus.BranchTargetE = 0; bus.CntClr = 0;
    m_busy = 0; m_flags = 0; m_pc = 0; m_err = 0; m_b = 0; m_t = 0;
    idle = st(0, 0, 0, 0, 4'b0, 0, 0, 0);

    //              rst br sel fw alu     st tgt     clr    flags  rv pc      fd fe err b  t
    vecs[0]  = mk(st(1, 0, 0, 0, 4'b0000, 0, 0,      0), 4'b0000, 0, 0,      0, 0, 0, 0, 0);
    vecs[1]  = mk(st(0, 0, 0, 1, 4'b0100, 0, 0,      0), 4'b0100, 0, 0,      0, 0, 0, 0, 0);
    vecs[2]  = mk(st(0, 1, 0, 0, 4'b0000, 0, 'h40,   0), 4'b0100, 1, 'h40,   1, 1, 0, 1, 1);
    vecs[3]  = mk(st(0, 1, 3, 1, 4'b0000, 0, 'h80,   0), 4'b0100, 0, 'h40,   0, 1, 0, 1, 1);
    vecs[4]  = mk(idle,                                  4'b0100, 0, 'h40,   0, 0, 0, 1, 1);
    vecs[5]  = mk(st(0, 0, 0, 1, 4'b1001, 0, 0,      0), 4'b1001, 0, 'h40,   0, 0, 0, 1, 1);
    vecs[6]  = mk(st(0, 1, 2, 0, 4'b0000, 0, 'h100,  0), 4'b1001, 1, 'h100,  1, 1, 0, 2, 2);
    vecs[7]  = mk(idle,                                  4'b1001, 0, 'h100,  0, 1, 0, 2, 2);
    vecs[8]  = mk(idle,                                  4'b1001, 0, 'h100,  0, 0, 0, 2, 2);
    vecs[9]  = mk(st(0, 0, 0, 1, 4'b1000, 0, 0,      0), 4'b1000, 0, 'h100,  0, 0, 0, 2, 2);
    vecs[10] = mk(st(0, 1, 2, 0, 4'b0000, 0, 'h200,  0), 4'b1000, 0, 'h100,  0, 0, 0, 3, 2);
    vecs[11] = mk(st(0, 0, 0, 1, 4'b0000, 0, 0,      0), 4'b0000, 0, 'h100,  0, 0, 0, 3, 2);
    vecs[12] = mk(st(0, 1, 0, 1, 4'b0100, 0, 'h300,  0), 4'b0100, 0, 'h100,  0, 0, 0, 4, 2);
    vecs[13] = mk(st(0, 1, 0, 0, 4'b0000, 1, 'h400,  0), 4'b0100, 0, 'h100,  0, 0, 0, 4, 2);
    vecs[14] = mk(st(0, 1, 0, 0, 4'b0000, 0, 'h400,  0), 4'b0100, 1, 'h400,  1, 1, 0, 5, 3);
    vecs[15] = mk(st(0, 1, 3, 0, 4'b0000, 1, 'h500,  0), 4'b0100, 0, 'h400,  0, 1, 0, 5, 3);
    vecs[16] = mk(st(0, 1, 3, 0, 4'b0000, 0, 'h500,  0), 4'b0100, 0, 'h400,  0, 0, 0, 5, 3);
    vecs[17] = mk(st(0, 1, 1, 0, 4'b0000, 0, 'h700,  0), 4'b0100, 0, 'h400,  0, 0, 1, 6, 3);
    vecs[18] = mk(st(0, 1, 3, 0, 4'b0000, 0, 'h600,  0), 4'b0100, 1, 'h600,  1, 1, 1, 7, 4);
    vecs[19] = mk(st(1, 0, 0, 0, 4'b0000, 0, 0,      0), 4'b0000, 0, 0,      0, 0, 0, 0, 0);
    vecs[20] = mk(idle,                                  4'b0000, 0, 0,      0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      do_cycle(vecs[i].s);
      chk($sformatf("vec%0d_flags", i),  bus.Flags,         vecs[i].ef);
      chk($sformatf("vec%0d_rv", i),     bus.RedirectValid, vecs[i].erv);
      chk($sformatf("vec%0d_pc", i),     bus.RedirectPC,    vecs[i].epc);
      chk($sformatf("vec%0d_fd", i),     bus.FlushD,        vecs[i].efd);
      chk($sformatf("vec%0d_fe", i),     bus.FlushE,        vecs[i].efe);
      chk($sformatf("vec%0d_err", i),    bus.CondErr,       vecs[i].eerr);
      chk($sformatf("vec%0d_bcnt", i),   bus.BranchCnt,     vecs[i].eb);
      chk($sformatf("vec%0d_tcnt", i),   bus.TakenCnt,      vecs[i].et);
    end

    // Drive both counters past all-ones; they must stick at the maximum.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      do_cycle(st(0, 1, 3, 0, 4'b0, 0, 32'h1000 + 32'(i * 4), 0));
      do_cycle(idle);
      do_cycle(idle);
    end
    chk("sat_taken",  bus.TakenCnt,  CNT_MAX);
    chk("sat_branch", bus.BranchCnt, CNT_MAX);

    // Clear coinciding with a taken branch: clear wins, redirect still happens.
    do_cycle(st(0, 1, 3, 0, 4'b0, 0, 'h44, 1));
    chk("clr_taken",  bus.TakenCnt,  0);
    chk("clr_branch", bus.BranchCnt, 0);
    chk("clr_rv",     bus.RedirectValid, 1);
    chk("clr_pc",     bus.RedirectPC, 'h44);
    do_cycle(idle);
    do_cycle(idle);

    // Reset while in the drain cycle.
    do_cycle(st(0, 1, 3, 0, 4'b0, 0, 'h88, 0));
    do_cycle(idle);
    do_cycle(st(1, 0, 0, 0, 4'b0, 0, 0, 0));
    chk("rst_drain_fe", bus.FlushE, 0);
    chk("rst_drain_pc", bus.RedirectPC, 0);

    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.rst   = ($urandom_range(0, 99) == 0);
      s.br    = $urandom_range(0, 1);
      s.sel   = 2'($urandom_range(0, 3));
      s.fw    = $urandom_range(0, 1);
      s.alu   = 4'($urandom_range(0, 15));
      s.stall = ($urandom_range(0, 3) == 0);
      s.tgt   = $urandom;
      s.clr   = ($urandom_range(0, 49) == 0);
      do_cycle(s);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
